// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - display/host arbiter and sequencer for the 2K x 18 display RAM
module vram_arb #(
    parameter int AW       = 11,
    parameter int DW       = 18,
    parameter int MAXBURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dsp_req,
    input  logic [AW-1:0] dsp_addr,
    output logic          dsp_gnt,
    output logic          dsp_vld,
    output logic [DW-1:0] dsp_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_vld,
    output logic [DW-1:0] host_rdata,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);
    localparam logic [3:0] MAX_CNT = 4'(MAXBURST);

    logic [3:0] cnt;
    logic       tag1_vld, tag1_host;
    logic       tag2_vld, tag2_host;

    // Display wins unless the host has already waited out a full burst.
    assign dsp_gnt  = !rst && dsp_req && (!host_req || cnt < MAX_CNT);
    assign host_gnt = !rst && host_req && (!dsp_req || cnt >= MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_di     <= '0;
            tag1_vld   <= 1'b0;
            tag1_host  <= 1'b0;
            tag2_vld   <= 1'b0;
            tag2_host  <= 1'b0;
            dsp_vld    <= 1'b0;
            host_vld   <= 1'b0;
            dsp_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            // A display grant with host_req high implies cnt < MAX_CNT, so this saturates.
            cnt <= (dsp_gnt && host_req) ? cnt + 4'd1 : 4'd0;

            ram_ce <= dsp_gnt || host_gnt;
            ram_we <= host_gnt && host_we;
            if (host_gnt) begin
                ram_addr <= host_addr;
                ram_di   <= host_wdata;
            end else if (dsp_gnt) begin
                ram_addr <= dsp_addr;
                ram_di   <= host_wdata;
            end

            tag1_vld  <= dsp_gnt || (host_gnt && !host_we);
            tag1_host <= host_gnt;
            tag2_vld  <= tag1_vld;
            tag2_host <= tag1_host;

            dsp_vld  <= tag2_vld && !tag2_host;
            host_vld <= tag2_vld && tag2_host;
            if (tag2_vld && !tag2_host)
                dsp_rdata <= ram_do;
            if (tag2_vld && tag2_host)
                host_rdata <= ram_do;
        end
    end
endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - randomized self-checking bench for vram_arb against a RAM-level model
module tb_vram_arb;
    localparam int AW = 11;
    localparam int DW = 18;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dsp_req = 1'b0;
    logic [AW-1:0] dsp_addr = '0;
    logic          dsp_gnt, dsp_vld;
    logic [DW-1:0] dsp_rdata;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt, host_vld;
    logic [DW-1:0] host_rdata;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do = '0;

    always #5 clk = ~clk;

    vram_arb #(.AW(AW), .DW(DW), .MAXBURST(MB)) dut (
        .clk(clk), .rst(rst),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_gnt(dsp_gnt),
        .dsp_vld(dsp_vld), .dsp_rdata(dsp_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_vld(host_vld),
        .host_rdata(host_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    logic [DW-1:0] mem [2048];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            else        ram_do <= mem[ram_addr];
        end
    end

    // The requester must keep a pending host request stable.
    logic          hq_p = 1'b0;
    logic          hw_p = 1'b0;
    logic [AW-1:0] ha_p = '0;
    logic [DW-1:0] hd_p = '0;
    always @(posedge clk) begin
        if (hq_p && host_req)
            assert (host_we == hw_p && host_addr == ha_p && host_wdata == hd_p)
                else $error("host request changed while pending");
        hq_p <= host_req && !host_gnt && !rst;
        hw_p <= host_we;
        ha_p <= host_addr;
        hd_p <= host_wdata;
    end

    typedef struct {
        int            cyc;
        bit            host;
        logic [DW-1:0] data;
    } ret_t;

    logic [DW-1:0] shadow [2048];
    ret_t          rq [$];
    int            burst = 0;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    bit            armed = 0;
    bit            mg_d = 0, mg_h = 0;
    logic          exp_ce = 0, exp_we = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_di = '0, last_d = '0, last_h = '0;
    string         pat = "";

    bit            cur_dr = 0, cur_hr = 0, cur_hw = 0;
    logic [AW-1:0] cur_da = '0, cur_ha = '0;
    logic [DW-1:0] cur_hd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle(input bit r, input bit dr, input logic [AW-1:0] da,
                         input bit hr, input bit hw, input logic [AW-1:0] ha,
                         input logic [DW-1:0] hd);
        bit   ed, eh, vd, vh;
        ret_t e;
        @(posedge clk);
        #1;
        rst = r; dsp_req = dr; dsp_addr = da;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        @(negedge clk);
        ed = 0; eh = 0;
        if (!r) begin
            if (dr && (!hr || burst < MB)) ed = 1;
            else if (hr) eh = 1;
        end
        check("dsp_gnt", dsp_gnt, ed);
        check("host_gnt", host_gnt, eh);
        if (ed) pat = {pat, "D"};
        if (eh) pat = {pat, "H"};
        if (armed) begin
            check("ram_ce", ram_ce, exp_ce);
            check("ram_we", ram_we, exp_we);
            check("ram_addr", ram_addr, exp_addr);
            check("ram_di", ram_di, exp_di);
            vd = 0; vh = 0;
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                e = rq.pop_front();
                if (e.host) begin vh = 1; last_h = e.data; end
                else        begin vd = 1; last_d = e.data; end
            end
            check("dsp_vld", dsp_vld, vd);
            check("host_vld", host_vld, vh);
            check("dsp_rdata", dsp_rdata, last_d);
            check("host_rdata", host_rdata, last_h);
        end
        if (r) begin
            burst = 0;
            rq.delete();
            exp_ce = 0; exp_we = 0; exp_addr = '0; exp_di = '0;
            last_d = '0; last_h = '0;
            armed = 1;
        end else begin
            exp_ce = ed || eh;
            exp_we = eh && hw;
            if (ed || eh) begin
                exp_addr = eh ? ha : da;
                exp_di   = hd;
                if (eh && hw) begin
                    shadow[ha] = hd;
                end else begin
                    e.cyc  = cyc + 3;
                    e.host = eh;
                    e.data = shadow[eh ? ha : da];
                    rq.push_back(e);
                end
            end
            // Consecutive display wins while the host waits.
            burst = (ed && hr) ? burst + 1 : 0;
        end
        mg_d = ed; mg_h = eh;
        cyc++;
    endtask

    task automatic rand_cycle(input bit r, input int dp, input int hp);
        if (dp == 0) cur_dr = 0;
        else if (!cur_dr || mg_d) begin
            cur_dr = ($urandom_range(99) < dp);
            cur_da = AW'($urandom);
        end
        if (hp == 0) cur_hr = 0;
        else if (!cur_hr || mg_h) begin
            cur_hr = ($urandom_range(99) < hp);
            cur_hw = $urandom_range(1);
            cur_ha = AW'($urandom);
            cur_hd = DW'($urandom);
        end
        cycle(r, cur_dr, cur_da, cur_hr, cur_hw, cur_ha, cur_hd);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]    = DW'(i * 37 + 5) ^ 18'h15a5a;
            shadow[i] = DW'(i * 37 + 5) ^ 18'h15a5a;
        end

        cycle(1, 1, 11'd9, 1, 0, 11'd10, '0);
        cycle(1, 1, 11'd9, 1, 0, 11'd10, '0);
        cycle(0, 1, 11'd9, 1, 0, 11'd10, '0);

        for (int a = 0; a < 3; a++) cycle(0, 1, AW'(a), 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 0, '0, '0);

        cycle(0, 0, '0, 1, 1, 11'h7FF, 18'h2AAAA);
        cycle(0, 0, '0, 1, 0, 11'h7FF, '0);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 0, '0, '0);
        check("host_rdata_7ff", host_rdata, 18'h2AAAA);

        mg_d = 1; mg_h = 1; cur_dr = 0; cur_hr = 0;
        pat = "";
        for (int i = 0; i < 20; i++) rand_cycle(0, 100, 100);
        check("burst_pattern", (pat.substr(0, 9) == "DDDDHDDDDH"), 1);
        for (int i = 0; i < 10; i++) rand_cycle(0, 0, 100);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 0, '0, '0);

        cycle(0, 1, 11'd5, 0, 0, '0, '0);
        cycle(1, 0, '0, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 0, '0, '0);
        cycle(0, 0, '0, 1, 0, 11'd5, '0);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 0, '0, '0);
        check("reread_after_abort", host_rdata, shadow[5]);

        for (int i = 0; i < 400; i++) rand_cycle($urandom_range(99) < 2, 60, 50);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 0, '0, '0);
        check("return_queue_drained", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
